// File: rtl/memory_stage.sv
// MEM stage of the uDLX pipeline: drives data memory over a req/ack handshake and registers MEM/WB.
// Optional MEM_TIMEOUT_EN adds an ack-wait timeout with a sticky mem_err_out flag.
module memory_stage #(
  parameter int unsigned PC_WIDTH       = 20,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_data_rd_en_in,
  input  logic                      mem_data_wr_en_in,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic [DATA_WIDTH-1:0]     alu_data_in,
  input  logic                      reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
  input  logic                      write_back_mux_sel_in,
  input  logic                      select_new_pc_in,
  input  logic [PC_WIDTH-1:0]       new_pc_in,
  input  logic                      dmem_ack,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [ADDR_WIDTH-1:0]     dmem_addr,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  output logic                      stall_out,
  output logic                      wb_reg_wr_en_out,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg_wr_addr_out,
  output logic                      wb_write_back_mux_sel_out,
  output logic [DATA_WIDTH-1:0]     wb_mem_data_out,
  output logic [DATA_WIDTH-1:0]     wb_alu_data_out,
  output logic                      select_new_pc_out,
  output logic [PC_WIDTH-1:0]       new_pc_out
`ifdef MEM_TIMEOUT_EN
  ,
  output logic                      mem_err_out
`endif
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                      state_q, state_d;
  logic                        hold_load_q, hold_load_d;
  logic                        hold_rwe_q, hold_rwe_d;
  logic [REG_ADDR_WIDTH-1:0]   hold_ra_q, hold_ra_d;
  logic                        hold_sel_q, hold_sel_d;
  logic [DATA_WIDTH-1:0]       hold_alu_q, hold_alu_d;
  logic                        hold_spc_q, hold_spc_d;
  logic [PC_WIDTH-1:0]         hold_npc_q, hold_npc_d;
  logic                        req_q, req_d;
  logic                        we_q, we_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic                        wb_en_q, wb_en_d;
  logic [REG_ADDR_WIDTH-1:0]   wb_ra_q, wb_ra_d;
  logic                        wb_sel_q, wb_sel_d;
  logic [DATA_WIDTH-1:0]       wb_mem_q, wb_mem_d;
  logic [DATA_WIDTH-1:0]       wb_alu_q, wb_alu_d;
  logic                        spc_q, spc_d;
  logic [PC_WIDTH-1:0]         npc_q, npc_d;
  logic                        access, timeout, commit;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  assign timeout     = (state_q == ST_WAIT) && (cnt_q == TO_LAST) && !dmem_ack;
  assign mem_err_out = err_q;
`else
  assign timeout = 1'b0;
`endif

  assign access    = mem_data_rd_en_in | mem_data_wr_en_in;
  assign commit    = (state_q == ST_WAIT) && (dmem_ack || timeout);
  assign stall_out = ((state_q == ST_IDLE) && access) || ((state_q == ST_WAIT) && !commit);

  // Next-state and pipe-register update.
  always_comb begin
    state_d     = state_q;
    hold_load_d = hold_load_q;
    hold_rwe_d  = hold_rwe_q;
    hold_ra_d   = hold_ra_q;
    hold_sel_d  = hold_sel_q;
    hold_alu_d  = hold_alu_q;
    hold_spc_d  = hold_spc_q;
    hold_npc_d  = hold_npc_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wb_en_d     = wb_en_q;
    wb_ra_d     = wb_ra_q;
    wb_sel_d    = wb_sel_q;
    wb_mem_d    = wb_mem_q;
    wb_alu_d    = wb_alu_q;
    spc_d       = spc_q;
    npc_d       = npc_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          state_d     = ST_WAIT;
          hold_load_d = mem_data_rd_en_in & ~mem_data_wr_en_in;
          hold_rwe_d  = reg_wr_en_in;
          hold_ra_d   = reg_wr_addr_in;
          hold_sel_d  = write_back_mux_sel_in;
          hold_alu_d  = alu_data_in;
          hold_spc_d  = select_new_pc_in;
          hold_npc_d  = new_pc_in;
          req_d       = 1'b1;
          we_d        = mem_data_wr_en_in;
          addr_d      = alu_data_in[ADDR_WIDTH+1:2];
          wdata_d     = mem_data_in;
          wb_en_d     = 1'b0;
          spc_d       = 1'b0;
`ifdef MEM_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end else begin
          wb_en_d  = reg_wr_en_in;
          wb_ra_d  = reg_wr_addr_in;
          wb_sel_d = write_back_mux_sel_in;
          wb_mem_d = '0;
          wb_alu_d = alu_data_in;
          spc_d    = select_new_pc_in;
          npc_d    = new_pc_in;
        end
      end
      ST_WAIT: begin
        if (commit) begin
          // A timed-out access still retires its slot but never writes the register file.
          state_d  = ST_IDLE;
          req_d    = 1'b0;
          wb_en_d  = hold_rwe_q & dmem_ack;
          wb_ra_d  = hold_ra_q;
          wb_sel_d = hold_sel_q;
          wb_mem_d = (hold_load_q && dmem_ack) ? dmem_rdata : '0;
          wb_alu_d = hold_alu_q;
          spc_d    = hold_spc_q;
          npc_d    = hold_npc_q;
`ifdef MEM_TIMEOUT_EN
          if (!dmem_ack) err_d = 1'b1;
`endif
        end else begin
          wb_en_d = 1'b0;
          spc_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_load_q <= 1'b0;
      hold_rwe_q  <= 1'b0;
      hold_ra_q   <= '0;
      hold_sel_q  <= 1'b0;
      hold_alu_q  <= '0;
      hold_spc_q  <= 1'b0;
      hold_npc_q  <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wb_en_q     <= 1'b0;
      wb_ra_q     <= '0;
      wb_sel_q    <= 1'b0;
      wb_mem_q    <= '0;
      wb_alu_q    <= '0;
      spc_q       <= 1'b0;
      npc_q       <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_load_q <= hold_load_d;
      hold_rwe_q  <= hold_rwe_d;
      hold_ra_q   <= hold_ra_d;
      hold_sel_q  <= hold_sel_d;
      hold_alu_q  <= hold_alu_d;
      hold_spc_q  <= hold_spc_d;
      hold_npc_q  <= hold_npc_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wb_en_q     <= wb_en_d;
      wb_ra_q     <= wb_ra_d;
      wb_sel_q    <= wb_sel_d;
      wb_mem_q    <= wb_mem_d;
      wb_alu_q    <= wb_alu_d;
      spc_q       <= spc_d;
      npc_q       <= npc_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign dmem_req                  = req_q;
  assign dmem_we                   = we_q;
  assign dmem_addr                 = addr_q;
  assign dmem_wdata                = wdata_q;
  assign wb_reg_wr_en_out          = wb_en_q;
  assign wb_reg_wr_addr_out        = wb_ra_q;
  assign wb_write_back_mux_sel_out = wb_sel_q;
  assign wb_mem_data_out           = wb_mem_q;
  assign wb_alu_data_out           = wb_alu_q;
  assign select_new_pc_out         = spc_q;
  assign new_pc_out                = npc_q;

endmodule
